// File: rtl/dsp48a1_pkg.sv
// Shared constants, tag bundle and FSM encoding for the DSP48A1 MAC sequencer.
package dsp48a1_pkg;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  localparam int OPM_PREADD_BIT    = 4;

  localparam int SLICE_LAT = 3;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // Bubbles keep Z=P with X=0 so P holds between and after terms.
  function automatic logic [7:0] opmode_of(
    input tag_t t,
    input logic preadd
  );
    logic [7:0] m;
    m = OPM_HOLD;
    if (t.valid) begin
      m = t.first ? OPM_FIRST : OPM_ACC;
    end
    m[OPM_PREADD_BIT] = t.valid & preadd;
    return m;
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Tag shift register that tracks each term through the slice's
// A1 -> M -> P register chain.
module mac_tag_pipe
  import dsp48a1_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output logic o_vld,
  output logic o_done
);

  tag_t r_pipe [SLICE_LAT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SLICE_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < SLICE_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_vld  = r_pipe[SLICE_LAT-1].valid;
  assign o_done = r_pipe[SLICE_LAT-1].valid
                & r_pipe[SLICE_LAT-1].last;

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Drives a DSP48A1 slice as an N_TERMS dot-product MAC engine.
// Define MAC_SEQ_PREADD_EN to add S_D and compute A*(D+B) via the pre-adder.
module dsp48a1_mac_seq
  import dsp48a1_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = $clog2(N_TERMS) + 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [17:0] S_A,
  input  logic [17:0] S_B,
`ifdef MAC_SEQ_PREADD_EN
  input  logic [17:0] S_D,
`endif
  output logic        R_VALID,
  input  logic        R_READY,
  output logic [47:0] R_DATA,
  output logic        R_CARRY,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [17:0] DSP_D,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  output logic        DSP_RSTP,
  input  logic [47:0] DSP_P,
  input  logic        DSP_CARRYOUT
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

`ifdef MAC_SEQ_PREADD_EN
  localparam logic PREADD = 1'b1;
  assign DSP_D = S_D;
`else
  localparam logic PREADD = 1'b0;
  assign DSP_D = '0;
`endif

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  tag_t             r_tag0;
  logic [17:0]      r_dsp_a;
  logic [17:0]      r_dsp_b;
  logic [7:0]       r_opmode;
  logic             r_sticky;
  logic             r_valid;
  logic [47:0]      r_data;
  logic             r_carry;

  logic w_issue;
  logic w_first;
  logic w_last;
  logic w_vld3;
  logic w_done3;
  logic w_load;

  assign S_READY = ~RST & (r_state == ACCUM);
  assign w_issue = S_VALID & S_READY;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST_CNT);
  assign w_load  = (r_state == CAPTURE)
                 & (~r_valid | R_READY);

  mac_tag_pipe u_tags (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_tag  (r_tag0),
    .o_vld  (w_vld3),
    .o_done (w_done3)
  );

  // OPMODE register sees the tag one edge after issue, aligning with A1REG.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dsp_a  <= '0;
      r_dsp_b  <= '0;
      r_tag0   <= '0;
      r_opmode <= '0;
    end else begin
      if (w_issue) begin
        r_dsp_a <= S_A;
        r_dsp_b <= S_B;
      end
      r_tag0.valid <= w_issue;
      r_tag0.first <= w_first;
      r_tag0.last  <= w_last;
      r_opmode     <= opmode_of(r_tag0, PREADD);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_issue) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_done3) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (w_load) r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sticky <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_carry  <= 1'b0;
    end else begin
      if (w_load) begin
        r_sticky <= 1'b0;
      end else if (w_vld3 & DSP_CARRYOUT) begin
        r_sticky <= 1'b1;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= DSP_P;
        r_carry <= r_sticky;
      end else if (R_READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign DSP_A      = r_dsp_a;
  assign DSP_B      = r_dsp_b;
  assign DSP_OPMODE = r_opmode;
  assign DSP_CE     = ~RST;
  assign DSP_RSTP   = RST;
  assign R_VALID    = r_valid;
  assign R_DATA     = r_data;
  assign R_CARRY    = r_carry;

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Directed bench for dsp48a1_mac_seq with a behavioural DSP48A1 slice.
// Build with MAC_SEQ_PREADD_EN defined to exercise the pre-adder path.
module tb_dsp48a1_mac_seq;

`ifdef MAC_SEQ_PREADD_EN
  localparam int NT = 2;
`else
  localparam int NT = 4;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [17:0] S_A = '0;
  logic [17:0] S_B = '0;
  logic [17:0] S_D = '0;
  logic        R_VALID;
  logic        R_READY = 1'b0;
  logic [47:0] R_DATA;
  logic        R_CARRY;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [17:0] DSP_D;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic        DSP_RSTP;
  logic [47:0] DSP_P;
  logic        DSP_CARRYOUT;
  logic        force_co = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  dsp48a1_mac_seq #(.N_TERMS(NT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .S_VALID      (S_VALID),
    .S_READY      (S_READY),
    .S_A          (S_A),
    .S_B          (S_B),
`ifdef MAC_SEQ_PREADD_EN
    .S_D          (S_D),
`endif
    .R_VALID      (R_VALID),
    .R_READY      (R_READY),
    .R_DATA       (R_DATA),
    .R_CARRY      (R_CARRY),
    .DSP_A        (DSP_A),
    .DSP_B        (DSP_B),
    .DSP_D        (DSP_D),
    .DSP_OPMODE   (DSP_OPMODE),
    .DSP_CE       (DSP_CE),
    .DSP_RSTP     (DSP_RSTP),
    .DSP_P        (DSP_P),
    .DSP_CARRYOUT (DSP_CARRYOUT)
  );

  always #5 CLK = ~CLK;

  // Slice model: DREG/A1REG/B1REG, MREG, OPMODEREG, PREG/CARRYOUTREG.
  logic signed [17:0] s_a1 = '0;
  logic signed [17:0] s_b1 = '0;
  logic        [17:0] s_d  = '0;
  logic signed [47:0] s_m  = '0;
  logic        [7:0]  s_opm = '0;
  logic        [47:0] s_p  = '0;
  logic               s_co = 1'b0;
  logic signed [35:0] w_prod;
  logic        [47:0] w_x;
  logic        [47:0] w_z;

  assign w_prod = s_a1 * s_b1;
  assign w_x = (s_opm[1:0] == 2'b01) ? s_m : 48'd0;
  assign w_z = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  assign DSP_P = s_p;
  assign DSP_CARRYOUT = s_co | force_co;

  always @(posedge CLK) begin
    if (DSP_RSTP) begin
      s_p  <= '0;
      s_co <= 1'b0;
    end else if (DSP_CE) begin
      {s_co, s_p} <= {1'b0, w_z} + {1'b0, w_x};
    end
    if (DSP_CE) begin
      s_a1  <= DSP_A;
      s_d   <= DSP_D;
`ifdef MAC_SEQ_PREADD_EN
      s_b1  <= s_d + DSP_B;
`else
      s_b1  <= DSP_B;
`endif
      s_m   <= {{12{w_prod[35]}}, w_prod};
      s_opm <= DSP_OPMODE;
    end
  end

  task automatic chk(input string tag,
                     input logic [47:0] got,
                     input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [17:0] a,
                      input logic [17:0] b,
                      input logic [17:0] d);
    int n;
    n = 0;
    S_VALID = 1'b1;
    S_A = a;
    S_B = b;
    S_D = d;
    while (!S_READY && n < 40) begin
      tick();
      n++;
    end
    chk("push_ready", 48'(S_READY), 48'd1);
    tick();
    S_VALID = 1'b0;
  endtask

  task automatic pop(input logic [47:0] exp_d, input logic exp_c);
    int n;
    n = 0;
    while (!R_VALID && n < 40) begin
      tick();
      n++;
    end
    chk("r_valid", 48'(R_VALID), 48'd1);
    chk("r_data", R_DATA, exp_d);
    chk("r_carry", 48'(R_CARRY), 48'(exp_c));
    R_READY = 1'b1;
    tick();
    R_READY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_s_ready", 48'(S_READY), 48'd0);
    chk("rst_r_valid", 48'(R_VALID), 48'd0);
    chk("rst_r_data", R_DATA, 48'd0);
    chk("rst_r_carry", 48'(R_CARRY), 48'd0);
    chk("rst_dsp_a", 48'(DSP_A), 48'd0);
    chk("rst_opmode", 48'(DSP_OPMODE), 48'h00);
    chk("rst_ce", 48'(DSP_CE), 48'd0);
    chk("rst_rstp", 48'(DSP_RSTP), 48'd1);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", 48'(S_READY), 48'd1);
    chk("post_rst_ce", 48'(DSP_CE), 48'd1);

`ifdef MAC_SEQ_PREADD_EN
    push(18'd2, 18'd1, 18'd10);
    push(18'd2, 18'd1, 18'd10);
    chk("pre_opm_first", 48'(DSP_OPMODE), 48'h11);
    tick();
    chk("pre_opm_acc", 48'(DSP_OPMODE), 48'h19);
    tick();
    chk("pre_opm_hold", 48'(DSP_OPMODE), 48'h08);
    pop(48'd44, 1'b0);
`else
    chk("dsp_d_zero", 48'(DSP_D), 48'd0);

    // 1*2+2*2+3*2+4*2 back-to-back, with latency probe
    push(18'd1, 18'd2, 18'd0);
    push(18'd2, 18'd2, 18'd0);
    chk("opm_first", 48'(DSP_OPMODE), 48'h01);
    push(18'd3, 18'd2, 18'd0);
    chk("opm_acc", 48'(DSP_OPMODE), 48'h09);
    push(18'd4, 18'd2, 18'd0);
    repeat (4) tick();
    chk("lat_edge4", 48'(R_VALID), 48'd0);
    tick();
    chk("lat_edge5", 48'(R_VALID), 48'd1);
    pop(48'd20, 1'b0);

    // one idle slot between terms 2 and 3
    push(18'd1, 18'd2, 18'd0);
    push(18'd2, 18'd2, 18'd0);
    tick();
    push(18'd3, 18'd2, 18'd0);
    chk("opm_bubble", 48'(DSP_OPMODE), 48'h08);
    push(18'd4, 18'd2, 18'd0);
    pop(48'd20, 1'b0);

    // back-pressure: second result waits behind an unconsumed first
    for (int i = 0; i < 4; i++) push(18'd1, 18'd5, 18'd0);
    for (int i = 0; i < 4; i++) push(18'd2, 18'd3, 18'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_data", R_DATA, 48'd20);
    end
    chk("hold_valid", 48'(R_VALID), 48'd1);
    chk("hold_s_ready", 48'(S_READY), 48'd0);
    R_READY = 1'b1;
    tick();
    R_READY = 1'b0;
    chk("nogap_valid", 48'(R_VALID), 48'd1);
    chk("nogap_data", R_DATA, 48'd24);
    pop(48'd24, 1'b0);

    // carry-out on one stage-3 slot sets R_CARRY for this vector only
    for (int i = 0; i < 4; i++) push(18'd1, 18'd1, 18'd0);
    force_co = 1'b1;
    tick();
    force_co = 1'b0;
    pop(48'd4, 1'b1);
    for (int i = 0; i < 4; i++) push(18'd1, 18'd1, 18'd0);
    pop(48'd4, 1'b0);

    // reset mid-vector discards the partial sum
    push(18'd7, 18'd7, 18'd0);
    push(18'd7, 18'd7, 18'd0);
    RST = 1'b1;
    #1;
    chk("midrst_ready", 48'(S_READY), 48'd0);
    tick();
    chk("midrst_opmode", 48'(DSP_OPMODE), 48'h00);
    RST = 1'b0;
    repeat (8) tick();
    chk("no_stale", 48'(R_VALID), 48'd0);
    for (int i = 0; i < 4; i++) push(18'd3, 18'd3, 18'd0);
    pop(48'd36, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
